msgdma_mem_responder: RTL and testbench

Avalon-MM bursting slave that terminates the DMA engine's 512-bit `mem` master port with a byte-enabled on-chip RAM. It lets the msgdma_bbb datapath run standalone, without board memory, for bring-up and simulation. It accepts read and write bursts of 1–7 beats and returns read data with a fixed pipeline latency. Only one transaction is in flight at a time.

---
 rtl/msgdma_mem_pkg.sv | 18 +
 rtl/msgdma_mem_ram.sv | 45 ++++
 rtl/msgdma_mem_responder.sv | 198 +++++++++++++++++++
 tb/tb_msgdma_mem_responder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/msgdma_mem_pkg.sv
// Shared definitions for the msgdma memory responder.
//   state_t            : responder FSM states
//   BYTES_PER_WORD     : byte lanes per 512-bit RAM word
//   WORD_OFFSET_W      : byte-offset bits below the word index
//   DEFAULT_DEPTH_LOG2 : default log2 of RAM depth in words
package msgdma_mem_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_ISSUE = 2'd2
    } state_t;

    localparam int BYTES_PER_WORD     = 64;
    localparam int WORD_OFFSET_W      = 6;
    localparam int DEFAULT_DEPTH_LOG2 = 10;

endpackage

// File: rtl/msgdma_mem_ram.sv
// Simple dual-port RAM with per-byte write enables and one registered read port.
// Contents are not initialised and are not affected by reset.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write word index
//   wr_be   : per-byte write enables
//   wr_data : write word
//   rd_en   : read strobe (loads rd_data on the next edge)
//   rd_addr : read word index
//   rd_data : registered read word
module msgdma_mem_ram #(
    parameter int DATA_W     = 512,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_W-1:0]     rd_data
);

    logic [DATA_W-1:0] mem_r [2**DEPTH_LOG2];

    // Byte-lane masked write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wr_be[b]) begin
                    mem_r[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Registered read port; a write at edge t is seen by a read at edge t+1.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/msgdma_mem_responder.sv
// Avalon-MM bursting slave backed by a byte-enabled on-chip RAM, terminating
// the DMA engine's 512-bit mem master. One transaction in flight at a time;
// read beats appear two cycles after the read command is accepted.
//   clk_clk, reset_reset_n : clock, asynchronous active-low reset
//   s_*                    : Avalon-MM slave port (s_debugaccess ignored)
//   err_flag / err_clr     : sticky protocol-error flag and its clear
module msgdma_mem_responder
    import msgdma_mem_pkg::*;
#(
    parameter int DATA_W     = 512,
    parameter int ADDR_W     = 48,
    parameter int BURST_W    = 3,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    output logic                s_waitrequest,
    output logic [DATA_W-1:0]   s_readdata,
    output logic                s_readdatavalid,
    input  logic [BURST_W-1:0]  s_burstcount,
    input  logic [DATA_W-1:0]   s_writedata,
    input  logic [ADDR_W-1:0]   s_address,
    input  logic                s_write,
    input  logic                s_read,
    input  logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_debugaccess,
    output logic                err_flag,
    input  logic                err_clr
);

    localparam logic [DEPTH_LOG2-1:0] IDX_ONE = DEPTH_LOG2'(1);
    localparam logic [BURST_W-1:0]    BC_ONE  = BURST_W'(1);
    localparam logic [BURST_W-1:0]    BC_ZERO = {BURST_W{1'b0}};

    state_t                  state_r, state_nxt;
    logic [DEPTH_LOG2-1:0]   idx_r, idx_nxt;
    logic [BURST_W-1:0]      rem_r, rem_nxt;
    logic [1:0]              occ_r, occ_nxt;
    logic                    ram_vld_r;
    logic                    wr_en_s, rd_en_s, err_set_s, accept_s, wait_nxt;
    logic [DEPTH_LOG2-1:0]   addr_idx_s, ram_addr_s;
    logic [DATA_W-1:0]       ram_rdata_s;
    logic                    unused_s;

    // Upper address bits alias the RAM; debugaccess has no effect.
    assign unused_s   = ^{s_debugaccess, s_address[ADDR_W-1:DEPTH_LOG2+WORD_OFFSET_W]};
    assign addr_idx_s = s_address[DEPTH_LOG2+WORD_OFFSET_W-1:WORD_OFFSET_W];
    assign accept_s   = (s_write || s_read) && !s_waitrequest;

    // Next-state, burst bookkeeping, RAM strobes and error detection.
    always_comb begin
        state_nxt  = state_r;
        idx_nxt    = idx_r;
        rem_nxt    = rem_r;
        wr_en_s    = 1'b0;
        rd_en_s    = 1'b0;
        err_set_s  = 1'b0;
        ram_addr_s = idx_r;
        case (state_r)
            IDLE: begin
                // Beat 0 goes straight to the RAM using the incoming address.
                ram_addr_s = addr_idx_s;
                if (accept_s) begin
                    if (s_address[WORD_OFFSET_W-1:0] != {WORD_OFFSET_W{1'b0}}) begin
                        err_set_s = 1'b1;
                    end else begin
                        err_set_s = err_set_s;
                    end
                    if (s_write && s_read) begin
                        err_set_s = 1'b1;
                    end else begin
                        err_set_s = err_set_s;
                    end
                    if (s_burstcount == BC_ZERO) begin
                        err_set_s = 1'b1;
                    end else begin
                        idx_nxt = addr_idx_s + IDX_ONE;
                        rem_nxt = s_burstcount - BC_ONE;
                        if (s_write) begin
                            wr_en_s = 1'b1;
                            if (s_burstcount != BC_ONE) begin
                                state_nxt = WR_BURST;
                            end else begin
                                state_nxt = IDLE;
                            end
                        end else begin
                            rd_en_s = 1'b1;
                            if (s_burstcount != BC_ONE) begin
                                state_nxt = RD_ISSUE;
                            end else begin
                                state_nxt = IDLE;
                            end
                        end
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            WR_BURST: begin
                if (s_read) begin
                    err_set_s = 1'b1;
                end else begin
                    err_set_s = 1'b0;
                end
                if (s_write && !s_waitrequest) begin
                    wr_en_s = 1'b1;
                    idx_nxt = idx_r + IDX_ONE;
                    rem_nxt = rem_r - BC_ONE;
                    if (rem_r == BC_ONE) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WR_BURST;
                    end
                end else begin
                    state_nxt = WR_BURST;
                end
            end
            RD_ISSUE: begin
                rd_en_s = 1'b1;
                idx_nxt = idx_r + IDX_ONE;
                rem_nxt = rem_r - BC_ONE;
                if (rem_r == BC_ONE) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = RD_ISSUE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Beats in flight: +1 per RAM read issued, -1 when a beat leaves the output register.
    always_comb begin
        occ_nxt  = occ_r + {1'b0, rd_en_s} - {1'b0, s_readdatavalid};
        wait_nxt = (state_nxt == RD_ISSUE) || (occ_nxt != 2'd0);
    end

    // FSM state and burst counters.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_r <= IDLE;
            idx_r   <= {DEPTH_LOG2{1'b0}};
            rem_r   <= BC_ZERO;
        end else begin
            state_r <= state_nxt;
            idx_r   <= idx_nxt;
            rem_r   <= rem_nxt;
        end
    end

    // Read pipeline, occupancy and stall; waitrequest resets high so the
    // first edge after reset release is always stalled.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ram_vld_r       <= 1'b0;
            occ_r           <= 2'd0;
            s_readdatavalid <= 1'b0;
            s_readdata      <= {DATA_W{1'b0}};
            s_waitrequest   <= 1'b1;
        end else begin
            ram_vld_r       <= rd_en_s;
            occ_r           <= occ_nxt;
            s_readdatavalid <= ram_vld_r;
            s_waitrequest   <= wait_nxt;
            if (ram_vld_r) begin
                s_readdata <= ram_rdata_s;
            end
        end
    end

    // Sticky error flag; a new error wins over a clear in the same cycle.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            err_flag <= 1'b0;
        end else if (err_set_s) begin
            err_flag <= 1'b1;
        end else if (err_clr) begin
            err_flag <= 1'b0;
        end
    end

    msgdma_mem_ram #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk_clk),
        .wr_en   (wr_en_s),
        .wr_addr (ram_addr_s),
        .wr_be   (s_byteenable),
        .wr_data (s_writedata),
        .rd_en   (rd_en_s),
        .rd_addr (ram_addr_s),
        .rd_data (ram_rdata_s)
    );

endmodule

// File: tb/tb_msgdma_mem_responder.sv
// Directed bench for msgdma_mem_responder. Inputs change on the falling
// edge; outputs are sampled on the falling edge.
module tb_msgdma_mem_responder;

    logic         clk_clk = 1'b0;
    logic         reset_reset_n = 1'b0;
    logic         s_waitrequest;
    logic [511:0] s_readdata;
    logic         s_readdatavalid;
    logic [2:0]   s_burstcount = 3'd0;
    logic [511:0] s_writedata = '0;
    logic [47:0]  s_address = 48'd0;
    logic         s_write = 1'b0;
    logic         s_read = 1'b0;
    logic [63:0]  s_byteenable = 64'd0;
    logic         s_debugaccess = 1'b0;
    logic         err_flag;
    logic         err_clr = 1'b0;

    int n_vec = 0;
    int n_miscompare = 0;

    logic [511:0] beat_q [8];
    logic [511:0] exp_q  [8];

    localparam logic [63:0] BE_ALL = {64{1'b1}};

    always #5 clk_clk = ~clk_clk;

    msgdma_mem_responder dut (
        .clk_clk         (clk_clk),
        .reset_reset_n   (reset_reset_n),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .s_burstcount    (s_burstcount),
        .s_writedata     (s_writedata),
        .s_address       (s_address),
        .s_write         (s_write),
        .s_read          (s_read),
        .s_byteenable    (s_byteenable),
        .s_debugaccess   (s_debugaccess),
        .err_flag        (err_flag),
        .err_clr         (err_clr)
    );

    task automatic check_vec(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (s_waitrequest && n < 20) begin
            @(negedge clk_clk);
            n++;
        end
        if (s_waitrequest) check_vec("ready_timeout", {511'd0, s_waitrequest}, 512'd0);
    endtask

    task automatic do_write(input logic [47:0] addr, input logic [2:0] bc, input logic [63:0] be);
        wait_ready();
        for (int k = 0; k < int'(bc); k++) begin
            s_write      = 1'b1;
            s_address    = addr;
            s_burstcount = bc;
            s_byteenable = be;
            s_writedata  = beat_q[k];
            check_vec("wr_wait", {511'd0, s_waitrequest}, 512'd0);
            @(posedge clk_clk);
            @(negedge clk_clk);
        end
        s_write = 1'b0;
    endtask

    // Read burst: beat k expected at the (k+2)th cycle after acceptance,
    // waitrequest high until the cycle after the last beat.
    task automatic do_read(input logic [47:0] addr, input logic [2:0] bc);
        wait_ready();
        s_read       = 1'b1;
        s_address    = addr;
        s_burstcount = bc;
        @(posedge clk_clk);
        @(negedge clk_clk);
        s_read = 1'b0;
        check_vec("rd_lat_valid", {511'd0, s_readdatavalid}, 512'd0);
        check_vec("rd_wait_first", {511'd0, s_waitrequest}, {511'd0, (bc != 3'd0)});
        for (int k = 0; k < int'(bc); k++) begin
            @(negedge clk_clk);
            check_vec("rd_valid", {511'd0, s_readdatavalid}, 512'd1);
            check_vec("rd_data", s_readdata, exp_q[k]);
            check_vec("rd_wait_hold", {511'd0, s_waitrequest}, 512'd1);
        end
        @(negedge clk_clk);
        check_vec("rd_valid_end", {511'd0, s_readdatavalid}, 512'd0);
        check_vec("rd_wait_end", {511'd0, s_waitrequest}, 512'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk_clk);
        check_vec("rst_wait", {511'd0, s_waitrequest}, 512'd1);
        check_vec("rst_valid", {511'd0, s_readdatavalid}, 512'd0);
        check_vec("rst_data", s_readdata, 512'd0);
        check_vec("rst_err", {511'd0, err_flag}, 512'd0);
        @(posedge clk_clk);
        #1 reset_reset_n = 1'b1;
        @(negedge clk_clk);
        check_vec("rel_wait_hold", {511'd0, s_waitrequest}, 512'd1);
        @(negedge clk_clk);
        check_vec("rel_wait_free", {511'd0, s_waitrequest}, 512'd0);

        // Single beat
        beat_q[0] = {64{8'hA5}};
        do_write(48'h40, 3'd1, BE_ALL);
        exp_q[0] = {64{8'hA5}};
        do_read(48'h40, 3'd1);
        check_vec("single_err", {511'd0, err_flag}, 512'd0);

        // 4-beat burst
        for (int i = 0; i < 4; i++) beat_q[i] = 512'(i);
        do_write(48'h1000, 3'd4, BE_ALL);
        for (int i = 0; i < 4; i++) exp_q[i] = 512'(i);
        do_read(48'h1000, 3'd4);

        // Byte enables
        beat_q[0] = {512{1'b1}};
        do_write(48'h2000, 3'd1, BE_ALL);
        beat_q[0] = 512'd0;
        do_write(48'h2000, 3'd1, 64'h0000_0000_0000_000F);
        exp_q[0] = {{480{1'b1}}, 32'h0};
        do_read(48'h2000, 3'd1);

        // Wrap from word 1023 to word 0
        beat_q[0] = {16{32'hDEADBEEF}};
        beat_q[1] = {16{32'h0BADF00D}};
        do_write(48'hFFC0, 3'd2, BE_ALL);
        exp_q[0] = {16{32'hDEADBEEF}};
        do_read(48'hFFC0, 3'd1);
        exp_q[0] = {16{32'h0BADF00D}};
        do_read(48'h0, 3'd1);
        check_vec("wrap_err", {511'd0, err_flag}, 512'd0);
        // Aliasing: upper address bits ignored
        do_read(48'h1_0000, 3'd1);

        // Misaligned address lands on word 1
        beat_q[0] = {8{64'h0123456789ABCDEF}};
        do_write(48'h41, 3'd1, BE_ALL);
        check_vec("misalign_err", {511'd0, err_flag}, 512'd1);
        exp_q[0] = {8{64'h0123456789ABCDEF}};
        do_read(48'h40, 3'd1);
        err_clr = 1'b1;
        @(posedge clk_clk);
        @(negedge clk_clk);
        err_clr = 1'b0;
        check_vec("err_clr", {511'd0, err_flag}, 512'd0);

        // Burstcount 0: no-op read, error raised
        do_read(48'h80, 3'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_clk);
            check_vec("bc0_valid", {511'd0, s_readdatavalid}, 512'd0);
        end
        check_vec("bc0_err", {511'd0, err_flag}, 512'd1);

        // Reset in the middle of a 4-beat read
        wait_ready();
        s_read = 1'b1;
        s_address = 48'h1000;
        s_burstcount = 3'd4;
        @(posedge clk_clk);
        @(negedge clk_clk);
        s_read = 1'b0;
        @(negedge clk_clk);
        check_vec("mid_beat0", s_readdata, 512'd0);
        @(negedge clk_clk);
        check_vec("mid_beat1_valid", {511'd0, s_readdatavalid}, 512'd1);
        check_vec("mid_beat1", s_readdata, 512'd1);
        reset_reset_n = 1'b0;
        #1;
        check_vec("mid_rst_valid", {511'd0, s_readdatavalid}, 512'd0);
        check_vec("mid_rst_wait", {511'd0, s_waitrequest}, 512'd1);
        check_vec("mid_rst_err", {511'd0, err_flag}, 512'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_clk);
            check_vec("mid_rst_hold_valid", {511'd0, s_readdatavalid}, 512'd0);
        end
        @(posedge clk_clk);
        #1 reset_reset_n = 1'b1;
        @(negedge clk_clk);
        check_vec("mid_rel_wait_hold", {511'd0, s_waitrequest}, 512'd1);
        check_vec("mid_rel_valid", {511'd0, s_readdatavalid}, 512'd0);
        @(negedge clk_clk);
        check_vec("mid_rel_wait_free", {511'd0, s_waitrequest}, 512'd0);
        check_vec("mid_rel_valid2", {511'd0, s_readdatavalid}, 512'd0);
        for (int i = 0; i < 4; i++) exp_q[i] = 512'(i);
        do_read(48'h1000, 3'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule
